// File: rtl/div_share_ctl_if.sv
// Bundle of requester, response and divider-side signals for div_share_ctl.
// master is the controller's view; slave is the view of the surrounding requesters, consumer and divider.
interface div_share_ctl_if #(
    parameter int N_REQ   = 4,
    parameter int BW_ID   = 2,
    parameter int BW_DEND = 4,
    parameter int BW_DSOR = 3
);
    logic [N_REQ-1:0]         REQ_VALID;
    logic [N_REQ-1:0]         REQ_READY;
    logic [N_REQ*BW_DEND-1:0] REQ_DIVIDEND;
    logic [N_REQ*BW_DSOR-1:0] REQ_DIVISOR;
    logic                     RSP_VALID;
    logic                     RSP_READY;
    logic [BW_ID-1:0]         RSP_ID;
    logic [BW_DEND-1:0]       RSP_QUOT;
    logic [BW_DSOR-1:0]       RSP_REM;
    logic                     RSP_DZ;
    logic                     DIV_START;
    logic [BW_DEND-1:0]       DIV_DIVIDEND;
    logic [BW_DSOR-1:0]       DIV_DIVISOR;
    logic                     DIV_BUSY;
    logic [BW_DEND-1:0]       DIV_QUOT;
    logic [BW_DSOR-1:0]       DIV_REM;

    modport master (
        input  REQ_VALID, REQ_DIVIDEND, REQ_DIVISOR, RSP_READY, DIV_BUSY, DIV_QUOT, DIV_REM,
        output REQ_READY, RSP_VALID, RSP_ID, RSP_QUOT, RSP_REM, RSP_DZ,
               DIV_START, DIV_DIVIDEND, DIV_DIVISOR
    );
    modport slave (
        output REQ_VALID, REQ_DIVIDEND, REQ_DIVISOR, RSP_READY, DIV_BUSY, DIV_QUOT, DIV_REM,
        input  REQ_READY, RSP_VALID, RSP_ID, RSP_QUOT, RSP_REM, RSP_DZ,
               DIV_START, DIV_DIVIDEND, DIV_DIVISOR
    );
endinterface

// File: rtl/div_share_ctl.sv
// Round-robin sharing of one sequential divider among N_REQ requesters.
// Divide-by-zero is answered locally; the divider only ever sees non-zero divisors.
module div_share_ctl #(
    parameter int N_REQ   = 4,
    parameter int BW_ID   = 2,
    parameter int BW_DEND = 4,
    parameter int BW_DSOR = 3
) (
    input logic             CLK,
    input logic             RST,
    div_share_ctl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [BW_ID-1:0]   ptr;
    logic [BW_DEND-1:0] op_dend;
    logic [BW_DSOR-1:0] op_dsor;
    logic [BW_ID-1:0]   rsp_id;
    logic [BW_DEND-1:0] rsp_quot;
    logic [BW_DSOR-1:0] rsp_rem;
    logic               rsp_dz;

    logic               grant_vld;
    logic [BW_ID-1:0]   grant_id;
    logic               accept;
    logic [BW_DEND-1:0] sel_dend;
    logic [BW_DSOR-1:0] sel_dsor;
    logic [BW_ID-1:0]   ptr_nxt;

    // Search downward in offset so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.REQ_VALID[(int'(ptr) + k) % N_REQ]) begin
                grant_vld = 1'b1;
                grant_id  = BW_ID'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // Holding off while the divider is busy also covers a reset that landed mid-division.
    assign accept   = (state == S_IDLE) && !bus.DIV_BUSY && grant_vld;
    assign sel_dend = bus.REQ_DIVIDEND[int'(grant_id)*BW_DEND +: BW_DEND];
    assign sel_dsor = bus.REQ_DIVISOR[int'(grant_id)*BW_DSOR +: BW_DSOR];
    assign ptr_nxt  = (grant_id == BW_ID'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        bus.REQ_READY = '0;
        if (accept) bus.REQ_READY[grant_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (sel_dsor == '0) ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (!bus.DIV_BUSY) state_nxt = S_RESP;
            S_RESP:  if (bus.RSP_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr      <= '0;
            op_dend  <= '0;
            op_dsor  <= '0;
            rsp_id   <= '0;
            rsp_quot <= '0;
            rsp_rem  <= '0;
            rsp_dz   <= 1'b0;
        end else if (accept) begin
            ptr     <= ptr_nxt;
            op_dend <= sel_dend;
            op_dsor <= sel_dsor;
            rsp_id  <= grant_id;
            if (sel_dsor == '0) begin
                rsp_quot <= '1;
                rsp_rem  <= '0;
                rsp_dz   <= 1'b1;
            end else begin
                rsp_dz   <= 1'b0;
            end
        end else if (state == S_WAIT && !bus.DIV_BUSY) begin
            rsp_quot <= bus.DIV_QUOT;
            rsp_rem  <= bus.DIV_REM;
        end
    end

    assign bus.DIV_START    = (state == S_ISSUE);
    assign bus.DIV_DIVIDEND = op_dend;
    assign bus.DIV_DIVISOR  = op_dsor;
    assign bus.RSP_VALID    = (state == S_RESP);
    assign bus.RSP_ID       = rsp_id;
    assign bus.RSP_QUOT     = rsp_quot;
    assign bus.RSP_REM      = rsp_rem;
    assign bus.RSP_DZ       = rsp_dz;
endmodule

// File: tb/tb_div_share_ctl.sv
// Bench for div_share_ctl: a default instance plus a 1-bit-operand instance, each with a divider model.
// Expected results come from plain division and a round-robin pick over the valid mask.
module tb_div_share_ctl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    div_share_ctl_if #(.N_REQ(4), .BW_ID(2), .BW_DEND(4), .BW_DSOR(3)) bus ();
    div_share_ctl_if #(.N_REQ(2), .BW_ID(1), .BW_DEND(1), .BW_DSOR(1)) bus1 ();

    div_share_ctl #(.N_REQ(4), .BW_ID(2), .BW_DEND(4), .BW_DSOR(3))
        u_dut (.CLK(CLK), .RST(RST), .bus(bus));
    div_share_ctl #(.N_REQ(2), .BW_ID(1), .BW_DEND(1), .BW_DSOR(1))
        u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    // Divider models: BUSY for BW_DEND-1 cycles after START (plus optional stretch), not affected by RST.
    int       dv_cnt = 0, dv_extra = 0, dv_starts = 0;
    logic [3:0] dv_q = '0;
    logic [2:0] dv_r = '0;
    always @(posedge CLK) begin
        if (bus.DIV_START) begin
            dv_cnt    <= 3 + dv_extra;
            dv_q      <= bus.DIV_DIVIDEND / bus.DIV_DIVISOR;
            dv_r      <= bus.DIV_DIVIDEND % bus.DIV_DIVISOR;
            dv_starts <= dv_starts + 1;
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
        end
    end
    assign bus.DIV_BUSY = (dv_cnt != 0);
    assign bus.DIV_QUOT = dv_q;
    assign bus.DIV_REM  = dv_r;

    logic dv1_q = 1'b0, dv1_r = 1'b0;
    always @(posedge CLK) begin
        if (bus1.DIV_START) begin
            dv1_q <= bus1.DIV_DIVIDEND / bus1.DIV_DIVISOR;
            dv1_r <= bus1.DIV_DIVIDEND % bus1.DIV_DIVISOR;
        end
    end
    assign bus1.DIV_BUSY = 1'b0;
    assign bus1.DIV_QUOT = dv1_q;
    assign bus1.DIV_REM  = dv1_r;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input int i, input int dend, input int dsor);
        bus.REQ_DIVIDEND[i*4 +: 4] = 4'(dend);
        bus.REQ_DIVISOR[i*3 +: 3]  = 3'(dsor);
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Leaves the bench 1 time unit after a posedge with RSP_VALID high; returns cycles waited.
    task automatic wait_rsp(input string name, output int waited);
        waited = 0;
        while (!bus.RSP_VALID && waited < 30) begin
            step();
            waited++;
        end
        if (!bus.RSP_VALID) begin
            n_tests++; n_fail++;
            $display("FAIL %s: response timeout after %0d cycles", name, waited);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.REQ_VALID = '0; bus.RSP_READY = 1'b0;
        bus1.REQ_VALID = '0; bus1.RSP_READY = 1'b0;
        step(); step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.REQ_DIVIDEND = '0; bus.REQ_DIVISOR = '0;
        bus1.REQ_DIVIDEND = '0; bus1.REQ_DIVISOR = '0;
        do_reset();
        n_tests++;
        if ({bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got v=%0b id=%0d q=%0d r=%0d dz=%0b want all 0",
                     bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ);
        end
        n_tests++;
        if ({bus.DIV_START, bus.DIV_DIVIDEND, bus.DIV_DIVISOR, bus.REQ_READY} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_div: got start=%0b dend=%0d dsor=%0d rdy=%b want all 0",
                     bus.DIV_START, bus.DIV_DIVIDEND, bus.DIV_DIVISOR, bus.REQ_READY);
        end
    endtask

    task automatic test_single();
        int s0, w;
        bus.RSP_READY = 1'b1;
        set_op(2, 13, 3);
        bus.REQ_VALID = 4'b0100;
        #1;
        s0 = dv_starts;
        n_tests++;
        if (bus.REQ_READY !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant: got %b want 0100", bus.REQ_READY);
        end
        step();
        bus.REQ_VALID = '0;
        n_tests++;
        if (bus.DIV_START !== 1'b1) begin
            n_fail++; $display("FAIL single_start: got %0b want 1", bus.DIV_START);
        end
        wait_rsp("single", w);
        n_tests++;
        if (w + 1 !== 6) begin
            n_fail++; $display("FAIL single_latency: got %0d want 6", w + 1);
        end
        n_tests++;
        if ({bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ} !== {2'd2, 4'd4, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got id=%0d q=%0d r=%0d dz=%0b want 2 4 1 0",
                     bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ);
        end
        n_tests++;
        if (dv_starts - s0 !== 1) begin
            n_fail++; $display("FAIL single_pulses: got %0d want 1", dv_starts - s0);
        end
        step();
    endtask

    task automatic test_round_robin();
        int exp_id[5]  = '{0, 1, 2, 3, 0};
        int exp_q[5]   = '{2, 4, 1, 0, 2};
        int exp_r[5]   = '{1, 1, 0, 0, 1};
        int t, w;
        do_reset();
        set_op(0, 15, 7); set_op(1, 9, 2); set_op(2, 6, 6); set_op(3, 0, 5);
        bus.REQ_VALID = 4'b1111;
        bus.RSP_READY = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            while (bus.REQ_READY == '0 && t < 20) begin step(); t++; end
            n_tests++;
            if (bus.REQ_READY !== 4'(1 << exp_id[n])) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want id %0d", n, bus.REQ_READY, exp_id[n]);
            end
            step();
            wait_rsp("rr", w);
            n_tests++;
            if (bus.RSP_ID !== 2'(exp_id[n]) || bus.RSP_QUOT !== 4'(exp_q[n]) || bus.RSP_REM !== 3'(exp_r[n])) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got id=%0d %0dr%0d want id=%0d %0dr%0d", n,
                         bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, exp_id[n], exp_q[n], exp_r[n]);
            end
            step();
        end
        bus.REQ_VALID = '0;
        step();
    endtask

    task automatic test_div_zero();
        int s0;
        set_op(1, 9, 0);
        bus.REQ_VALID = 4'b0010;
        bus.RSP_READY = 1'b1;
        #1;
        s0 = dv_starts;
        n_tests++;
        if (bus.REQ_READY !== 4'b0010) begin
            n_fail++; $display("FAIL dz_grant: got %b want 0010", bus.REQ_READY);
        end
        step();
        bus.REQ_VALID = '0;
        n_tests++;
        if ({bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ} !== {1'b1, 2'd1, 4'd15, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL dz_rsp: got v=%0b id=%0d q=%0d r=%0d dz=%0b want 1 1 15 0 1",
                     bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ);
        end
        step();
        n_tests++;
        if (dv_starts != s0 || bus.DIV_START !== 1'b0) begin
            n_fail++; $display("FAIL dz_nostart: got %0d pulses want 0", dv_starts - s0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        set_op(3, 11, 4); set_op(0, 5, 1);
        bus.REQ_VALID = 4'b1000;
        bus.RSP_READY = 1'b0;
        #1;
        step();
        bus.REQ_VALID = 4'b0001;
        wait_rsp("bp", w);
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if ({bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ, bus.REQ_READY}
                !== {1'b1, 2'd3, 4'd2, 3'd3, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b id=%0d q=%0d r=%0d rdy=%b want 1 3 2 3 0000", c,
                         bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.REQ_READY);
            end
            step();
        end
        bus.RSP_READY = 1'b1;
        step();
        n_tests++;
        if (bus.REQ_READY !== 4'b0001) begin
            n_fail++; $display("FAIL bp_next_grant: got %b want 0001", bus.REQ_READY);
        end
        step();
        bus.REQ_VALID = '0;
        wait_rsp("bp2", w);
        n_tests++;
        if (bus.RSP_ID !== 2'd0 || bus.RSP_QUOT !== 4'd5 || bus.RSP_REM !== 3'd0) begin
            n_fail++; $display("FAIL bp_rsp2: got id=%0d %0dr%0d want id=0 5r0", bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM);
        end
        step();
    endtask

    task automatic test_reset_wait();
        int  t, w;
        bit  bad;
        do_reset();
        dv_extra = 2;
        set_op(1, 7, 2);
        bus.REQ_VALID = 4'b0010;
        bus.RSP_READY = 1'b1;
        #1;
        step();
        bus.REQ_VALID = '0;
        step(); step();
        RST = 1'b1;
        set_op(0, 14, 5); set_op(3, 3, 1);
        bus.REQ_VALID = 4'b1001;
        step();
        RST = 1'b0;
        t = 0; bad = 0;
        while (bus.REQ_READY == '0 && t < 20) begin
            if (bus.RSP_VALID !== 1'b0 || bus.DIV_START !== 1'b0) bad = 1;
            step(); t++;
        end
        n_tests++;
        if (bad || t !== 3) begin
            n_fail++; $display("FAIL rstw_hold: got %0d idle cycles (bad=%0b) want 3 quiet", t, bad);
        end
        n_tests++;
        if (bus.REQ_READY !== 4'b0001 || bus.DIV_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL rstw_grant: got rdy=%b busy=%0b want 0001 0", bus.REQ_READY, bus.DIV_BUSY);
        end
        dv_extra = 0;
        step();
        bus.REQ_VALID = '0;
        wait_rsp("rstw", w);
        n_tests++;
        if (bus.RSP_ID !== 2'd0 || bus.RSP_QUOT !== 4'd2 || bus.RSP_REM !== 3'd4) begin
            n_fail++; $display("FAIL rstw_rsp: got id=%0d %0dr%0d want id=0 2r4", bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM);
        end
        step();
    endtask

    task automatic test_random();
        int m_ptr = 0;
        int dend[4], dsor[4];
        int win, t, w, eq, er;
        logic [3:0] mask;
        bit bad;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                dend[i] = $urandom_range(0, 15);
                dsor[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7);
                set_op(i, dend[i], dsor[i]);
            end
            mask = 4'($urandom_range(1, 15));
            bus.REQ_VALID = mask;
            bus.RSP_READY = 1'b0;
            #1;
            win = rr_pick(m_ptr, mask);
            t = 0;
            while (bus.REQ_READY == '0 && t < 20) begin step(); t++; end
            n_tests++;
            if (bus.REQ_READY !== 4'(1 << win)) begin
                n_fail++; $display("FAIL rand_grant%0d: got %b want id %0d (mask %b)", n, bus.REQ_READY, win, mask);
            end
            m_ptr = (win + 1) % 4;
            step();
            bad = 0; t = 0;
            while (!bus.RSP_VALID && t < 30) begin
                if (bus.REQ_READY !== 4'b0000) bad = 1;
                step(); t++;
            end
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                if (bus.REQ_READY !== 4'b0000) bad = 1;
                step();
            end
            eq = (dsor[win] == 0) ? 15 : dend[win] / dsor[win];
            er = (dsor[win] == 0) ? 0 : dend[win] % dsor[win];
            n_tests++;
            if (bad || bus.RSP_VALID !== 1'b1 || bus.RSP_ID !== 2'(win) || bus.RSP_QUOT !== 4'(eq)
                || bus.RSP_REM !== 3'(er) || bus.RSP_DZ !== (dsor[win] == 0)) begin
                n_fail++;
                $display("FAIL rand_rsp%0d: got v=%0b id=%0d %0dr%0d dz=%0b bad=%0b want id=%0d %0dr%0d dz=%0b",
                         n, bus.RSP_VALID, bus.RSP_ID, bus.RSP_QUOT, bus.RSP_REM, bus.RSP_DZ, bad,
                         win, eq, er, dsor[win] == 0);
            end
            bus.RSP_READY = 1'b1;
            bus.REQ_VALID = '0;
            step();
        end
        bus.RSP_READY = 1'b0;
    endtask

    task automatic test_edge_param();
        int t;
        bus1.REQ_DIVIDEND = 2'b01;
        bus1.REQ_DIVISOR  = 2'b01;
        bus1.REQ_VALID    = 2'b01;
        bus1.RSP_READY    = 1'b1;
        #1;
        n_tests++;
        if (bus1.REQ_READY !== 2'b01) begin
            n_fail++; $display("FAIL edge_grant: got %b want 01", bus1.REQ_READY);
        end
        step();
        bus1.REQ_VALID = '0;
        t = 1;
        while (!bus1.RSP_VALID && t < 20) begin step(); t++; end
        n_tests++;
        if (t !== 3 || bus1.RSP_QUOT !== 1'b1 || bus1.RSP_REM !== 1'b0 || bus1.RSP_DZ !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_rsp: got latency %0d q=%0d r=%0d dz=%0b want 3 1 0 0",
                     t, bus1.RSP_QUOT, bus1.RSP_REM, bus1.RSP_DZ);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_backpressure();
        test_reset_wait();
        test_random();
        test_edge_param();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
